// File: rtl/xrv32i_ifetch_pkg.sv
// Shared fetch-unit definitions: FSM state encoding, buffer depth limits and bus device select.
// Defining XRV32I_IFETCH_FAULT_EN adds the HALT state used after a misaligned redirect.
package xrv32i_ifetch_pkg;

  localparam int BUF_DEPTH_MIN = 2;
  localparam int BUF_DEPTH_MAX = 4;
  localparam int ENTRY_W       = 64;

  // Device select lives in the top address nibble of the simulation bus.
  localparam int         DEV_SEL_LSB  = 28;
  localparam logic [3:0] DEV_SEL_IMEM = 4'h0;
  localparam logic [3:0] DEV_SEL_DMEM = 4'h1;
  localparam logic [3:0] DEV_SEL_UART = 4'h2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FLUSH = 3'd3
`ifdef XRV32I_IFETCH_FAULT_EN
    , ST_HALT = 3'd4
`endif
  } fetch_state_e;

  // Only 2 and 4 are meaningful depths; anything else collapses to one of them.
  function automatic int legal_depth(input int d);
    return (d >= BUF_DEPTH_MAX) ? BUF_DEPTH_MAX : BUF_DEPTH_MIN;
  endfunction

endpackage

// File: rtl/xrv32i_ifetch_if.sv
// Instruction-fetch bus: fetch unit is master, memory/bus fabric is slave.
interface xrv32i_ifetch_if;

  // Handshake: master holds bus_req_out with a stable bus_addr_out until a cycle
  // with bus_grant_in=1; the slave later raises bus_ack_in for exactly one cycle
  // with bus_data_in valid. One transaction is outstanding at a time.
  logic        bus_req_out;
  logic [31:0] bus_addr_out;
  logic        bus_grant_in;
  logic        bus_ack_in;
  logic [31:0] bus_data_in;

  modport master (
    output bus_req_out,
    output bus_addr_out,
    input  bus_grant_in,
    input  bus_ack_in,
    input  bus_data_in
  );

  modport slave (
    input  bus_req_out,
    input  bus_addr_out,
    output bus_grant_in,
    output bus_ack_in,
    output bus_data_in
  );

endinterface

// File: rtl/xrv32i_ifetch_fifo.sv
// Instruction buffer: {addr, data} entries, synchronous flush that beats push and pop.
module xrv32i_ifetch_fifo
  import xrv32i_ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [ENTRY_W-1:0]       din,
  output logic [ENTRY_W-1:0]       dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               full;
  logic               push_ok;
  logic               pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; readers only look at it while the count is non-zero.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/xrv32i_ifetch.sv
// RV32I instruction fetch: bus fetch FSM feeding an instruction buffer toward the core.
// Build option XRV32I_IFETCH_FAULT_EN: misaligned redirects raise fault_out and halt fetching.
module xrv32i_ifetch
  import xrv32i_ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jump_in,
  input  logic [31:0]           pc_in,
  input  logic                  stall_in,
  output logic [31:0]           inst_out,
  output logic [31:0]           inst_addr_out,
  output logic                  inst_valid_out,
  xrv32i_ifetch_if.master       bus,
`ifdef XRV32I_IFETCH_FAULT_EN
  output logic                  fault_out,
`endif
  output fetch_state_e          fsm_state
);

  localparam int DEPTH = legal_depth(BUF_DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fetch_state_e       state;
  fetch_state_e       state_nx;
  logic [31:0]        fetch_pc;
  logic [31:0]        fetch_pc_nx;
  logic [31:0]        tx_addr;
  logic [31:0]        jump_pc;
  logic               jump_ok;
  logic               fault_hit;
  logic               push;
  logic               pop;
  logic               flush;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_after;
  logic [ENTRY_W-1:0] head;
  logic               empty;

`ifdef XRV32I_IFETCH_FAULT_EN
  logic fault_q;

  assign fault_hit = jump_in && (pc_in[1:0] != 2'b00) && (state != ST_HALT);
  assign jump_ok   = jump_in && !fault_hit && (state != ST_HALT);
  assign fault_out = fault_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fault_q <= 1'b0;
    else      fault_q <= fault_q | fault_hit;
  end
`else
  assign fault_hit = 1'b0;
  assign jump_ok   = jump_in;
`endif

  assign jump_pc        = pc_in & 32'hFFFF_FFFC;
  assign flush          = jump_ok || fault_hit;
  assign inst_valid_out = !empty;
  assign pop            = inst_valid_out && !stall_in && !flush;
  assign inst_out       = inst_valid_out ? head[31:0]  : 32'h0;
  assign inst_addr_out  = inst_valid_out ? head[63:32] : 32'h0;
  assign count_after    = count + CNT_W'(1) - CNT_W'(pop);
  assign fsm_state      = state;

  xrv32i_ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ({fetch_pc, bus.bus_data_in}),
    .dout  (head),
    .count (count),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      tx_addr  <= '0;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      // Address of the in-flight access, kept stable while a redirect drains it.
      if (state == ST_REQ) tx_addr <= fetch_pc;
    end
  end

  always_comb begin
    state_nx         = state;
    fetch_pc_nx      = fetch_pc;
    push             = 1'b0;
    bus.bus_req_out  = 1'b0;
    bus.bus_addr_out = 32'h0;
    unique case (state)
      ST_IDLE: begin
        if (count < DEPTH_C) state_nx = ST_REQ;
      end
      ST_REQ: begin
        bus.bus_req_out  = 1'b1;
        bus.bus_addr_out = fetch_pc;
        if (bus.bus_grant_in) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        bus.bus_req_out  = 1'b1;
        bus.bus_addr_out = tx_addr;
        if (bus.bus_ack_in) begin
          push        = 1'b1;
          fetch_pc_nx = fetch_pc + 32'd4;
          state_nx    = (count_after < DEPTH_C) ? ST_REQ : ST_IDLE;
        end
      end
      ST_FLUSH: begin
        bus.bus_req_out  = 1'b1;
        bus.bus_addr_out = tx_addr;
        if (bus.bus_ack_in) state_nx = ST_REQ;
      end
`ifdef XRV32I_IFETCH_FAULT_EN
      ST_HALT: begin
        state_nx = ST_HALT;
      end
`endif
      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    // A redirect discards any same-cycle ack; a still-pending access must drain in FLUSH.
    if (jump_ok) begin
      push        = 1'b0;
      fetch_pc_nx = jump_pc;
      if ((state == ST_WAIT || state == ST_FLUSH) && !bus.bus_ack_in) state_nx = ST_FLUSH;
      else                                                           state_nx = ST_REQ;
    end

`ifdef XRV32I_IFETCH_FAULT_EN
    if (fault_hit) begin
      push     = 1'b0;
      state_nx = ST_HALT;
    end
`endif
  end

endmodule

// File: tb/tb_xrv32i_ifetch.sv
// Bench for xrv32i_ifetch: vector table, redirect/reset/wrap sequences and a random bus run.
// Build option XRV32I_IFETCH_FAULT_EN enables the fault sequence.
module tb_xrv32i_ifetch;
  import xrv32i_ifetch_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst1, rst2;
  logic         jump1, stall1, jump2, stall2;
  logic [31:0]  pc1, pc2;
  logic [31:0]  inst1, iaddr1, inst2, iaddr2;
  logic         valid1, valid2;
  fetch_state_e st1, st2;
`ifdef XRV32I_IFETCH_FAULT_EN
  logic         fault1, fault2;
`endif

  xrv32i_ifetch_if bus1 ();
  xrv32i_ifetch_if bus2 ();

  xrv32i_ifetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut1 (
    .clk(clk), .rst(rst1), .jump_in(jump1), .pc_in(pc1), .stall_in(stall1),
    .inst_out(inst1), .inst_addr_out(iaddr1), .inst_valid_out(valid1), .bus(bus1),
`ifdef XRV32I_IFETCH_FAULT_EN
    .fault_out(fault1),
`endif
    .fsm_state(st1)
  );

  xrv32i_ifetch #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst2), .jump_in(jump2), .pc_in(pc2), .stall_in(stall2),
    .inst_out(inst2), .inst_addr_out(iaddr2), .inst_valid_out(valid2), .bus(bus2),
`ifdef XRV32I_IFETCH_FAULT_EN
    .fault_out(fault2),
`endif
    .fsm_state(st2)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus1_drive(input logic g, input logic a, input logic [31:0] d);
    bus1.bus_grant_in = g;
    bus1.bus_ack_in   = a;
    bus1.bus_data_in  = d;
  endtask

  task automatic bus2_drive(input logic g, input logic a, input logic [31:0] d);
    bus2.bus_grant_in = g;
    bus2.bus_ack_in   = a;
    bus2.bus_data_in  = d;
  endtask

  // Memory image served by the random-run slave.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) + 32'h0000_0013;
  endfunction

  typedef struct {
    logic        stall;
    logic        grant;
    logic        ack;
    logic [31:0] data;
    logic        exp_valid;
    logic [31:0] exp_inst;
    logic [31:0] exp_addr;
    logic        exp_req;
    logic [31:0] exp_baddr;
  } vec_t;

  vec_t vecs[11];

  // ---------------- random-run model state ----------------
  logic [31:0] exp_next;
  logic [31:0] tx;
  logic [31:0] rpc;
  bit          outstanding;
  bit          jumped;
  bit          rj;
  bit          rs;
  int          delay;
  int          pops;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          32'h0, 1'b1, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0,          32'h0, 1'b1, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0013,  1'b1, 32'h0000_0013,  32'h0, 1'b1, 32'h4};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,          1'b1, 32'h0000_0013,  32'h0, 1'b1, 32'h4};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h0010_0093,  1'b1, 32'h0000_0013,  32'h0, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_0013,  32'h0, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0010_0093,  32'h4, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          32'h0, 1'b1, 32'h8};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0,          32'h0, 1'b1, 32'h8};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF,  1'b1, 32'hDEAD_BEEF,  32'h8, 1'b1, 32'hC};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          32'h0, 1'b1, 32'hC};

    rst1 = 1'b0; rst2 = 1'b0;
    jump1 = 1'b0; stall1 = 1'b1; pc1 = 32'h0;
    jump2 = 1'b0; stall2 = 1'b1; pc2 = 32'h0;
    bus1_drive(1'b0, 1'b0, 32'h0);
    bus2_drive(1'b0, 1'b0, 32'h0);

    // ---------------- reset values ----------------
    tick(); tick();
    check("rst_valid", {31'h0, valid1}, 32'h0);
    check("rst_inst", inst1, 32'h0);
    check("rst_iaddr", iaddr1, 32'h0);
    check("rst_req", {31'h0, bus1.bus_req_out}, 32'h0);
    check("rst_baddr", bus1.bus_addr_out, 32'h0);
    check("rst_state", 32'(st1), 32'(ST_IDLE));
    check("rst2_baddr", bus2.bus_addr_out, 32'h0);
    rst1 = 1'b1;

    // ---------------- vector table: first fetch, stall fill, drain ----------------
    for (int i = 0; i < 11; i++) begin
      stall1 = vecs[i].stall;
      bus1_drive(vecs[i].grant, vecs[i].ack, vecs[i].data);
      tick();
      check($sformatf("vec%0d_valid", i), {31'h0, valid1}, {31'h0, vecs[i].exp_valid});
      check($sformatf("vec%0d_inst", i), inst1, vecs[i].exp_inst);
      check($sformatf("vec%0d_iaddr", i), iaddr1, vecs[i].exp_addr);
      check($sformatf("vec%0d_req", i), {31'h0, bus1.bus_req_out}, {31'h0, vecs[i].exp_req});
      check($sformatf("vec%0d_baddr", i), bus1.bus_addr_out, vecs[i].exp_baddr);
    end

    // ---------------- redirect while waiting, late ack discarded ----------------
    bus1_drive(1'b1, 1'b0, 32'h0);
    tick();
    check("j39_wait", 32'(st1), 32'(ST_WAIT));
    bus1_drive(1'b0, 1'b0, 32'h0);
    jump1 = 1'b1; pc1 = 32'h0000_0100;
    tick();
    check("j39_flush", 32'(st1), 32'(ST_FLUSH));
    check("j39_req_held", {31'h0, bus1.bus_req_out}, 32'h1);
    check("j39_valid0", {31'h0, valid1}, 32'h0);
    jump1 = 1'b0;
    tick();
    check("j39_req_held2", {31'h0, bus1.bus_req_out}, 32'h1);
    bus1_drive(1'b0, 1'b1, 32'hBAD0_BAD0);
    tick();
    check("j39_discard", {31'h0, valid1}, 32'h0);
    check("j39_state", 32'(st1), 32'(ST_REQ));
    check("j39_baddr", bus1.bus_addr_out, 32'h0000_0100);
    bus1_drive(1'b0, 1'b0, 32'h0);
    tick();
    check("j39_no_stale", {31'h0, valid1}, 32'h0);

    // ---------------- redirect and ack in the same cycle ----------------
    bus1_drive(1'b1, 1'b0, 32'h0);
    tick();
    check("j40_wait_baddr", bus1.bus_addr_out, 32'h0000_0100);
    bus1_drive(1'b0, 1'b1, 32'h1111_1111);
    jump1 = 1'b1; pc1 = 32'h0000_0200;
    tick();
    check("j40_valid0", {31'h0, valid1}, 32'h0);
    check("j40_state", 32'(st1), 32'(ST_REQ));
    check("j40_baddr", bus1.bus_addr_out, 32'h0000_0200);
    jump1 = 1'b0;
    bus1_drive(1'b1, 1'b0, 32'h0);
    tick();
    bus1_drive(1'b0, 1'b1, 32'h2222_2222);
    tick();
    check("j40_fetch_valid", {31'h0, valid1}, 32'h1);
    check("j40_fetch_iaddr", iaddr1, 32'h0000_0200);
    check("j40_fetch_inst", inst1, 32'h2222_2222);
    check("j40_next_baddr", bus1.bus_addr_out, 32'h0000_0204);

    // ---------------- redirect flushes a stalled, valid head ----------------
    bus1_drive(1'b0, 1'b0, 32'h0);
    stall1 = 1'b1; jump1 = 1'b1; pc1 = 32'h0000_0040;
    tick();
    check("j30_valid0", {31'h0, valid1}, 32'h0);
    check("j30_baddr", bus1.bus_addr_out, 32'h0000_0040);
    jump1 = 1'b0; stall1 = 1'b0;

    // ---------------- reset in the middle of a wait ----------------
    bus1_drive(1'b1, 1'b0, 32'h0);
    tick();
    check("r32_wait", 32'(st1), 32'(ST_WAIT));
    bus1_drive(1'b0, 1'b0, 32'h0);
    rst1 = 1'b0;
    #1;
    check("r32_state", 32'(st1), 32'(ST_IDLE));
    check("r32_req", {31'h0, bus1.bus_req_out}, 32'h0);
    rst1 = 1'b1;
    bus1_drive(1'b0, 1'b1, 32'h3333_3333);
    tick();
    check("r32_ack_ignored", {31'h0, valid1}, 32'h0);
    tick();
    check("r32_ack_ignored2", {31'h0, valid1}, 32'h0);
    check("r32_baddr", bus1.bus_addr_out, 32'h0);
    bus1_drive(1'b0, 1'b0, 32'h0);

`ifdef XRV32I_IFETCH_FAULT_EN
    // ---------------- misaligned redirect halts fetching ----------------
    jump1 = 1'b1; pc1 = 32'h0000_0102;
    tick();
    jump1 = 1'b0;
    check("f42_fault", {31'h0, fault1}, 32'h1);
    check("f42_state", 32'(st1), 32'(ST_HALT));
    for (int k = 0; k < 3; k++) begin
      bus1_drive(1'b1, 1'b1, 32'h0);
      tick();
      check("f42_req0", {31'h0, bus1.bus_req_out}, 32'h0);
      check("f42_fault_held", {31'h0, fault1}, 32'h1);
      check("f42_valid0", {31'h0, valid1}, 32'h0);
    end
    bus1_drive(1'b0, 1'b0, 32'h0);
    rst1 = 1'b0;
    #1;
    check("f42_fault_clr", {31'h0, fault1}, 32'h0);
    rst1 = 1'b1;
`endif

    // ---------------- wrap at top of memory, depth-4 fill and drain ----------------
    rst2 = 1'b1;
    tick();
    check("w41_first_baddr", bus2.bus_addr_out, 32'hFFFF_FFFC);
    bus2_drive(1'b1, 1'b0, 32'h0);
    tick();
    bus2_drive(1'b0, 1'b1, 32'h0000_0013);
    tick();
    check("w41_baddr_wrap", bus2.bus_addr_out, 32'h0000_0000);
    check("w41_iaddr", iaddr2, 32'hFFFF_FFFC);
    check("w41_valid", {31'h0, valid2}, 32'h1);
    for (int k = 1; k < 4; k++) begin
      bus2_drive(1'b1, 1'b0, 32'h0);
      tick();
      bus2_drive(1'b0, 1'b1, 32'h0000_1000 + 32'(k));
      tick();
      check($sformatf("d4_req_%0d", k), {31'h0, bus2.bus_req_out}, (k < 3) ? 32'h1 : 32'h0);
    end
    bus2_drive(1'b0, 1'b0, 32'h0);
    tick();
    check("d4_idle_full", {31'h0, bus2.bus_req_out}, 32'h0);
    stall2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("d4_order_%0d", k), iaddr2, 32'hFFFF_FFFC + 32'(4 * k));
      tick();
    end
    check("d4_drained", {31'h0, valid2}, 32'h0);

    // ---------------- random bus run against a stream model ----------------
    // Model: after each redirect the core must see consecutive words from the
    // target address, each carrying the memory contents of its own address.
    rst1 = 1'b0; stall1 = 1'b0; jump1 = 1'b0;
    bus1_drive(1'b0, 1'b0, 32'h0);
    tick();
    rst1 = 1'b1;
    exp_next = 32'h0; outstanding = 1'b0; jumped = 1'b0; pops = 0; delay = 0; tx = 32'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (jumped) check("rnd_flush_valid", {31'h0, valid1}, 32'h0);
      if (valid1) begin
        check("rnd_iaddr", iaddr1, exp_next);
        check("rnd_inst", inst1, mem_f(exp_next));
      end
      rj  = ($urandom_range(0, 31) == 0);
      rs  = ($urandom_range(0, 3) == 0);
`ifdef XRV32I_IFETCH_FAULT_EN
      rpc = $urandom & 32'hFFFF_FFFC;
`else
      rpc = $urandom;
`endif
      jump1 = rj; stall1 = rs; pc1 = rpc;
      if (valid1 && !rs && !rj) begin
        exp_next = exp_next + 32'd4;
        pops++;
      end
      if (rj) exp_next = rpc & 32'hFFFF_FFFC;
      jumped = rj;
      bus1_drive(1'b0, 1'b0, 32'h0);
      if (outstanding) begin
        if (delay == 0) begin
          bus1_drive(1'b0, 1'b1, mem_f(tx));
          outstanding = 1'b0;
        end else begin
          delay--;
        end
      end else if (bus1.bus_req_out && !rj && ($urandom_range(0, 1) == 1)) begin
        bus1_drive(1'b1, 1'b0, 32'h0);
        tx = bus1.bus_addr_out;
        outstanding = 1'b1;
        delay = $urandom_range(0, 2);
      end
      tick();
    end
    check("rnd_progress", (pops >= 100) ? 32'h1 : 32'h0, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xrv32i_ifetch.md
XRV32I_IFETCH -- requirements
Module: xrv32i_ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, instruction buffer entries; legal values 2 or 4.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 jump_in  input  1  redirect request from core.
REQ-006 pc_in  input  32  redirect target, sampled when jump_in=1.
REQ-007 stall_in  input  1  core cannot accept an instruction this cycle.
REQ-008 inst_out  output  32  instruction word to core.
REQ-009 inst_addr_out  output  32  address of inst_out.
REQ-010 inst_valid_out  output  1  inst_out/inst_addr_out are valid.
REQ-011 bus_req_out  output  1  device request bit into the simulation bus.
REQ-012 bus_addr_out  output  32  bus access address.
REQ-013 bus_grant_in  input  1  bus held for this master.
REQ-014 bus_ack_in  input  1  bus_data_in valid this cycle.
REQ-015 bus_data_in  input  32  read data from bus.
REQ-016 fault_out  output  1  misaligned redirect fault; present only with XRV32I_IFETCH_FAULT_EN.

Function
REQ-017 FSM states: IDLE, REQ, WAIT, FLUSH (plus HALT when fault enabled).
REQ-018 IDLE: bus_req_out=0; go to REQ next cycle when buffer count < BUF_DEPTH.
REQ-019 REQ: bus_req_out=1, bus_addr_out=fetch_pc; on bus_grant_in=1 go to WAIT.
REQ-020 WAIT: bus_req_out=1 held; on bus_ack_in=1 push {fetch_pc, bus_data_in}, fetch_pc+=4, go to REQ if count after push < BUF_DEPTH, else IDLE.
REQ-021 Request is issued only with a free slot, so a push never overflows the buffer.
REQ-022 inst_valid_out = buffer non-empty; oldest entry drives inst_out/inst_addr_out; pop when inst_valid_out=1 and stall_in=0.
REQ-023 Fetch-to-core latency: ack in cycle N gives inst_valid_out=1 in cycle N+1 if buffer was empty.
REQ-024 Simultaneous push and pop: count unchanged, order preserved.
REQ-025 fetch_pc 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000, no flag.
REQ-026 jump_in=1: buffer flushed same edge, inst_valid_out=0 next cycle, fetch_pc=pc_in.
REQ-027 jump_in in REQ or IDLE: next state REQ with new fetch_pc.
REQ-028 jump_in in WAIT without ack: go to FLUSH, hold bus_req_out, discard the next ack, then REQ.
REQ-029 jump_in with bus_ack_in same cycle: ack data discarded, jump wins, next state REQ.
REQ-030 jump_in overrides a simultaneous pop; stall_in ignored for flush.

Reset
REQ-031 While rst=0: state IDLE, fetch_pc=RESET_PC, buffer empty, inst_out=0, inst_addr_out=0, inst_valid_out=0, bus_req_out=0, bus_addr_out=0, fault_out=0.
REQ-032 Reset asserted mid-WAIT abandons the transaction; the first ack after release is ignored unless a new REQ was granted.

Configuration
REQ-033 Macro XRV32I_IFETCH_FAULT_EN defined: jump_in with pc_in[1:0]!=0 sets fault_out=1, flushes buffer, enters HALT (bus_req_out=0) until reset.
REQ-034 Macro undefined: fault_out port absent, pc_in[1:0] forced to 2'b00, no HALT state.

Structure
REQ-035 FSM state encodings, BUF_DEPTH limits and the device-select constants belong in the shared core defines file.
REQ-036 Buffer SHALL be a sub-module xrv32i_ifetch_fifo (64-bit entries, push/pop/flush, count output).

Verification
REQ-037 Reset release, bus grants next cycle, ack after 1 cycle with data 32'h0000_0013 -> inst_valid_out=1, inst_addr_out=0, inst_out=32'h13; next bus_addr_out=4.
REQ-038 stall_in=1 held, continuous acks -> exactly BUF_DEPTH pushes, then IDLE with bus_req_out=0; release stall -> entries popped in order 0,4.
REQ-039 jump_in with pc_in=32'h100 while in WAIT, ack arrives 2 cycles later -> that ack discarded, next bus_addr_out=32'h100, no stale inst_valid_out.
REQ-040 jump_in and bus_ack_in same cycle -> buffer empty next cycle, fetch_pc=pc_in.
REQ-041 RESET_PC=32'hFFFF_FFFC, one ack -> next bus_addr_out=32'h0000_0000.
REQ-042 With XRV32I_IFETCH_FAULT_EN, jump to 32'h102 -> fault_out=1, bus_req_out=0 until rst=0.
